// File: rtl/host_link_pkg.sv
// Shared definitions for the host link: word field layout and elaboration-time helpers.
package host_link_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_CH_W       = 4;

  // A PCIe word is {chan, payload}; the channel field sits directly above the payload.
  localparam int CHAN_LSB = DEFAULT_DATA_WIDTH;

  typedef logic [DEFAULT_CH_W-1:0] chan_t;

  function automatic int chan_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/host_link_fifo.sv
// Per-channel inbound FIFO; full is judged before the same-cycle read, so a write into a full FIFO is refused.
module host_link_fifo
  import host_link_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_wr;
  logic                  do_rd;

  assign full     = (count == CNT_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign do_wr    = wr_en && !full;
  assign do_rd    = rd_valid && rd_ready;

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (do_wr && !do_rd) begin
        count <= count + CNT_W'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/host_link_mux.sv
// Host link multiplexer: demuxes one PCIe word stream into per-channel FIFOs and
// round-robin merges per-channel outbound streams back onto one PCIe word stream.
module host_link_mux
  import host_link_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int CH_W         = 4,
  parameter int DEPTH        = 8,
  localparam int PCIE_WIDTH  = CH_W + DATA_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [PCIE_WIDTH-1:0]              pcie_in_bits,
  input  logic                               pcie_in_valid,
  output logic                               pcie_in_ready,
  output logic [PCIE_WIDTH-1:0]              pcie_out_bits,
  output logic                               pcie_out_valid,
  input  logic                               pcie_out_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] rx_bits,
  output logic [NUM_CHANNELS-1:0]            rx_valid,
  input  logic [NUM_CHANNELS-1:0]            rx_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] tx_bits,
  input  logic [NUM_CHANNELS-1:0]            tx_valid,
  output logic [NUM_CHANNELS-1:0]            tx_ready,
  output logic                               err_bad_chan
);

  localparam int                CHAN_OFS   = chan_lsb(DATA_WIDTH);
  localparam int                PTR_W      = clog2(NUM_CHANNELS);
  localparam int                IDX_W      = PTR_W + 1;
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(NUM_CHANNELS - 1);
  localparam logic [IDX_W-1:0]  NUM_CH_IDX = IDX_W'(NUM_CHANNELS);
  localparam logic [CH_W:0]     NUM_CH_EXT = (CH_W + 1)'(NUM_CHANNELS);

  logic                    in_stg_valid;
  logic [CH_W-1:0]         in_stg_chan;
  logic [DATA_WIDTH-1:0]   in_stg_data;
  logic                    in_stg_legal;
  logic                    sel_full;
  logic                    in_drain;
  logic                    in_take;
  logic [NUM_CHANNELS-1:0] fifo_full;
  logic [NUM_CHANNELS-1:0] fifo_wr;

  logic                    out_stg_valid;
  logic [CH_W-1:0]         out_stg_chan;
  logic [DATA_WIDTH-1:0]   out_stg_data;
  logic                    can_load;
  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        cand;
  logic [DATA_WIDTH-1:0]   grant_data;

  // The extra top bit keeps the comparison correct when NUM_CHANNELS == 2**CH_W.
  assign in_stg_legal = ({1'b0, in_stg_chan} < NUM_CH_EXT);

  always_comb begin
    sel_full = 1'b0;
    fifo_wr  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (in_stg_chan == CH_W'(k)) begin
        sel_full   = fifo_full[k];
        fifo_wr[k] = in_stg_valid;
      end
    end
  end

  // Ready looks only at the staged word, never at the incoming one.
  assign in_drain      = in_stg_valid && (!in_stg_legal || !sel_full);
  assign pcie_in_ready = !reset && (!in_stg_valid || in_drain);
  assign in_take       = pcie_in_valid && pcie_in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_stg_valid <= 1'b0;
      in_stg_chan  <= '0;
      in_stg_data  <= '0;
      err_bad_chan <= 1'b0;
    end else begin
      if (in_take) begin
        in_stg_valid <= 1'b1;
        in_stg_chan  <= pcie_in_bits[CHAN_OFS +: CH_W];
        in_stg_data  <= pcie_in_bits[DATA_WIDTH-1:0];
      end else if (in_drain) begin
        in_stg_valid <= 1'b0;
      end
      if (in_drain && !in_stg_legal) begin
        err_bad_chan <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_fifo
      host_link_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
      ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (fifo_wr[g]),
        .wr_data (in_stg_data),
        .full    (fifo_full[g]),
        .rd_valid(rx_valid[g]),
        .rd_data (rx_bits[g*DATA_WIDTH +: DATA_WIDTH]),
        .rd_ready(rx_ready[g])
      );
    end
  endgenerate

  assign can_load = !out_stg_valid || pcie_out_ready;

  // Search upward from rr_ptr with wrap; the first requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cand = {1'b0, rr_ptr} + IDX_W'(i);
      if (cand >= NUM_CH_IDX) begin
        cand = cand - NUM_CH_IDX;
      end
      if (!grant_found && tx_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign grant_data = tx_bits[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    tx_ready = '0;
    if (!reset && can_load && grant_found) begin
      tx_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_stg_valid <= 1'b0;
      out_stg_chan  <= '0;
      out_stg_data  <= '0;
      rr_ptr        <= '0;
    end else if (can_load) begin
      out_stg_valid <= grant_found;
      if (grant_found) begin
        out_stg_chan <= CH_W'(grant_idx);
        out_stg_data <= grant_data;
        rr_ptr       <= (grant_idx == LAST_PTR) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

  assign pcie_out_valid = out_stg_valid;
  assign pcie_out_bits  = {out_stg_chan, out_stg_data};

endmodule

// File: tb/tb_host_link_mux.sv
// Scoreboard bench for host_link_mux: stimulus pushes expected words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_host_link_mux;

  localparam int NUM_CHANNELS = 4;
  localparam int DATA_WIDTH   = 64;
  localparam int CH_W         = 4;
  localparam int DEPTH        = 8;
  localparam int PCIE_WIDTH   = CH_W + DATA_WIDTH;

  logic                               clock = 1'b0;
  logic                               reset;
  logic [PCIE_WIDTH-1:0]              pcie_in_bits;
  logic                               pcie_in_valid;
  logic                               pcie_in_ready;
  logic [PCIE_WIDTH-1:0]              pcie_out_bits;
  logic                               pcie_out_valid;
  logic                               pcie_out_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] rx_bits;
  logic [NUM_CHANNELS-1:0]            rx_valid;
  logic [NUM_CHANNELS-1:0]            rx_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] tx_bits;
  logic [NUM_CHANNELS-1:0]            tx_valid;
  logic [NUM_CHANNELS-1:0]            tx_ready;
  logic                               err_bad_chan;

  logic [PCIE_WIDTH-1:0] rx_q [$];
  logic [PCIE_WIDTH-1:0] out_q [$];
  logic [PCIE_WIDTH-1:0] mon_exp;
  int errors = 0;
  int checks = 0;
  int tx_seq   [NUM_CHANNELS];
  int tx_limit [NUM_CHANNELS];
  int used;

  always #5 clock = ~clock;

  host_link_mux #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .DATA_WIDTH  (DATA_WIDTH),
    .CH_W        (CH_W),
    .DEPTH       (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pcie_in_bits  (pcie_in_bits),
    .pcie_in_valid (pcie_in_valid),
    .pcie_in_ready (pcie_in_ready),
    .pcie_out_bits (pcie_out_bits),
    .pcie_out_valid(pcie_out_valid),
    .pcie_out_ready(pcie_out_ready),
    .rx_bits       (rx_bits),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_bits       (tx_bits),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .err_bad_chan  (err_bad_chan)
  );

  task automatic checkOutput(input string name, input logic [PCIE_WIDTH-1:0] actual,
                             input logic [PCIE_WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [DATA_WIDTH-1:0] payload(input int k, input int n);
    return 64'hC0DE_0000_0000_0000 | (64'(k) << 8) | 64'(n);
  endfunction

  // Present one inbound word and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [CH_W-1:0] chan, input logic [DATA_WIDTH-1:0] data);
    int waited;
    waited        = 0;
    pcie_in_bits  = {chan, data};
    pcie_in_valid = 1'b1;
    do begin
      @(negedge clock);
      waited++;
    end while (!pcie_in_ready && waited < 50);
    if (!pcie_in_ready) reportTimeout("in_accept");
    @(posedge clock);
    #1;
    pcie_in_valid = 1'b0;
  endtask

  task automatic waitRxDrain(input int budget);
    int n;
    n = 0;
    while (rx_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (rx_q.size() != 0) reportTimeout("rx_drain");
  endtask

  task automatic refreshTx(input int k);
    tx_valid[k] = (tx_seq[k] < tx_limit[k]);
    tx_bits[k*DATA_WIDTH +: DATA_WIDTH] = payload(k, tx_seq[k]);
  endtask

  // Drive the tx side until every expected outbound word is seen, optionally stalling pcie_out_ready.
  task automatic driveTx(input int budget, input int stall_at, input int stall_len, output int cycles);
    logic [NUM_CHANNELS-1:0] fire;
    logic [PCIE_WIDTH-1:0]   held;
    cycles = 0;
    held   = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) refreshTx(k);
    while (out_q.size() != 0 && cycles < budget) begin
      @(negedge clock);
      fire = tx_valid & tx_ready;
      if (!pcie_out_ready) begin
        checkOutput("stall_tx_ready", PCIE_WIDTH'(tx_ready), '0);
        if (cycles == stall_at) held = pcie_out_bits;
        else checkOutput("stall_bits_hold", pcie_out_bits, held);
      end
      @(posedge clock);
      #1;
      cycles++;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (fire[k]) begin
          tx_seq[k]++;
          refreshTx(k);
        end
      end
      pcie_out_ready = !(cycles >= stall_at && cycles < stall_at + stall_len);
    end
    if (out_q.size() != 0) reportTimeout("tx_burst");
  endtask

  // Monitor: every completed rx or pcie_out handshake is matched against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (rx_valid[k] && rx_ready[k]) begin
          if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_unexpected: ch%0d got %h with nothing expected", k,
                     rx_bits[k*DATA_WIDTH +: DATA_WIDTH]);
          end else begin
            mon_exp = rx_q.pop_front();
            checkOutput("rx_word", {CH_W'(k), rx_bits[k*DATA_WIDTH +: DATA_WIDTH]}, mon_exp);
          end
        end
      end
      if (pcie_out_valid && pcie_out_ready) begin
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL out_unexpected: got %h with nothing expected", pcie_out_bits);
        end else begin
          mon_exp = out_q.pop_front();
          checkOutput("out_word", pcie_out_bits, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    pcie_in_bits   = '0;
    pcie_in_valid  = 1'b0;
    pcie_out_ready = 1'b0;
    rx_ready       = '0;
    tx_bits        = '0;
    tx_valid       = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      tx_seq[k]   = 0;
      tx_limit[k] = 0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_in_ready", PCIE_WIDTH'(pcie_in_ready), '0);
    checkOutput("reset_out_valid", PCIE_WIDTH'(pcie_out_valid), '0);
    checkOutput("reset_rx_valid", PCIE_WIDTH'(rx_valid), '0);
    checkOutput("reset_tx_ready", PCIE_WIDTH'(tx_ready), '0);
    checkOutput("reset_err", PCIE_WIDTH'(err_bad_chan), '0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    rx_ready = '1;
    @(negedge clock);
    checkOutput("post_reset_in_ready", PCIE_WIDTH'(pcie_in_ready), 1);
    @(posedge clock);
    #1;

    $display("[TB] single word to channel 2");
    rx_q.push_back({4'd2, 64'hDEAD});
    applyStimulus(4'd2, 64'hDEAD);
    @(posedge clock);
    @(negedge clock);
    checkOutput("single_rx_valid", PCIE_WIDTH'(rx_valid), PCIE_WIDTH'(4'b0100));
    checkOutput("single_rx_bits", PCIE_WIDTH'(rx_bits[2*DATA_WIDTH +: DATA_WIDTH]), PCIE_WIDTH'(64'hDEAD));
    waitRxDrain(20);

    $display("[TB] fill channel 1 past its depth");
    rx_ready = 4'b1101;
    for (int i = 0; i < DEPTH + 1; i++) begin
      rx_q.push_back({4'd1, 64'h100 + 64'(i)});
      applyStimulus(4'd1, 64'h100 + 64'(i));
    end
    repeat (2) begin
      @(negedge clock);
      checkOutput("full_in_ready", PCIE_WIDTH'(pcie_in_ready), '0);
      checkOutput("full_rx_valid", PCIE_WIDTH'(rx_valid), PCIE_WIDTH'(4'b0010));
      @(posedge clock);
      #1;
    end
    rx_ready = '1;
    waitRxDrain(40);
    @(negedge clock);
    checkOutput("drained_in_ready", PCIE_WIDTH'(pcie_in_ready), 1);
    @(posedge clock);
    #1;

    $display("[TB] illegal channel then legal word");
    applyStimulus(4'd7, 64'hBAD);
    @(posedge clock);
    @(negedge clock);
    checkOutput("bad_chan_err", PCIE_WIDTH'(err_bad_chan), 1);
    checkOutput("bad_chan_no_rx", PCIE_WIDTH'(rx_valid), '0);
    @(posedge clock);
    #1;
    rx_q.push_back({4'd3, 64'h3333});
    applyStimulus(4'd3, 64'h3333);
    waitRxDrain(20);
    @(negedge clock);
    checkOutput("bad_chan_sticky", PCIE_WIDTH'(err_bad_chan), 1);
    @(posedge clock);
    #1;

    $display("[TB] round-robin burst with a 5-cycle stall");
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        out_q.push_back({CH_W'(k), payload(k, n)});
      end
    end
    for (int k = 0; k < NUM_CHANNELS; k++) tx_limit[k] = 3;
    pcie_out_ready = 1'b1;
    driveTx(60, 4, 5, used);
    checkOutput("burst_cycles_ok", PCIE_WIDTH'(used <= 18), 1);

    $display("[TB] reset with data in flight");
    rx_ready = '0;
    for (int i = 0; i < 4; i++) applyStimulus(4'd0, 64'h500 + 64'(i));
    applyStimulus(4'd2, 64'h52);
    pcie_out_ready = 1'b0;
    tx_bits[2*DATA_WIDTH +: DATA_WIDTH] = payload(2, 9);
    tx_valid = 4'b0100;
    @(posedge clock);
    #1;
    tx_valid = '0;
    @(negedge clock);
    checkOutput("pre_reset_out_valid", PCIE_WIDTH'(pcie_out_valid), 1);
    checkOutput("pre_reset_out_chan", PCIE_WIDTH'(pcie_out_bits[PCIE_WIDTH-1 -: CH_W]), 2);
    checkOutput("pre_reset_rx_valid", PCIE_WIDTH'(rx_valid), PCIE_WIDTH'(4'b0101));
    @(posedge clock);
    #1;
    reset          = 1'b1;
    pcie_out_ready = 1'b1;
    tx_valid       = '1;
    @(negedge clock);
    checkOutput("in_reset_in_ready", PCIE_WIDTH'(pcie_in_ready), '0);
    checkOutput("in_reset_tx_ready", PCIE_WIDTH'(tx_ready), '0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    tx_valid = '0;
    rx_ready = '1;
    @(negedge clock);
    checkOutput("after_reset_rx_valid", PCIE_WIDTH'(rx_valid), '0);
    checkOutput("after_reset_out_valid", PCIE_WIDTH'(pcie_out_valid), '0);
    checkOutput("after_reset_err", PCIE_WIDTH'(err_bad_chan), '0);
    checkOutput("after_reset_in_ready", PCIE_WIDTH'(pcie_in_ready), 1);
    @(posedge clock);
    #1;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      tx_seq[k]   = 0;
      tx_limit[k] = 1;
      out_q.push_back({CH_W'(k), payload(k, 0)});
    end
    driveTx(20, 100, 0, used);
    repeat (4) @(posedge clock);
    #1;
    checkOutput("final_rx_q_empty", PCIE_WIDTH'(rx_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
